accel_sequencer: RTL and testbench
==================================

# accel_sequencer

Command sequencer sitting directly upstream of the SPI command handler in the accelerometer driver. After reset it issues the accelerometer init writes: soft reset, filter control, then power control to enter measurement mode. It then polls the X/Y/Z 8-bit data registers at a fixed interval. Each command is presented on the handler's instruction/address/data inputs and handed off using the handler's ready level. Read results are captured into sample registers for the display/application logic.

## Interface
Parameters:
- SAMPLE_GAP, 1000000 — clk cycles idled between the end of a Z read and the next X read (≥1).
- WATCHDOG, 2000000 — max clk cycles allowed in ISSUE or BUSY before declaring a fault (must exceed the handler's 40 ms POWER_CTL timeout).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled only at step boundaries.
- i_CMD_Ready  in  1  handler idle and not stalled (level).
- i_CMD_Data  in  8  byte returned by the handler for the last read.
- o_CMD_Instruction  out  8  0x0A write, 0x0B read, 0xFF none.
- o_CMD_Address  out  8  register address.
- o_CMD_Data  out  8  write payload (0x00 for reads).
- o_Sample_X / o_Sample_Y / o_Sample_Z  out  8 each  last captured axis bytes.
- o_Sample_Valid  out  1  one-cycle pulse when X, Y and Z are all updated.
- o_Init_Done  out  1  high once the POWER_CTL write completes; sticky until reset.
- o_Fault  out  1  watchdog expired; sticky until reset.

## Operation
- Step table, index 0..5:
  - 0: WRITE 0x1F ← 0x52
  - 1: WRITE 0x2C ← 0x13
  - 2: WRITE 0x2D ← 0x02
  - 3: READ 0x08 → X
  - 4: READ 0x09 → Y
  - 5: READ 0x0A → Z
- Step index is 3 bits. After step 5 it wraps to 3, never to 0.
- i_CMD_Ready is registered once into rdy_q. All decisions use rdy_q.
- States:
  - IDLE: outputs instruction 0xFF. If enable=1 and rdy_q=1, go to ISSUE.
  - ISSUE: drives the step's instruction, address and data. When rdy_q=0 (handler accepted), go to BUSY.
  - BUSY: drives instruction 0xFF so the handler re-parks in its idle state. When rdy_q=1, go to CAPTURE.
  - CAPTURE: one cycle.
    - For a read step, latch i_CMD_Data into the step's axis register.
    - Step 2 sets o_Init_Done.
    - Step 5 pulses o_Sample_Valid and goes to GAP.
    - Any other step increments the index and goes to ISSUE if enable=1, otherwise IDLE.
  - GAP: counts SAMPLE_GAP cycles, sets the index to 3, then goes to ISSUE if enable=1, otherwise IDLE.
  - FAULT: instruction 0xFF, o_Fault=1. Terminal until reset.
- Watchdog:
  - One counter, cleared on every entry to ISSUE or BUSY.
  - When it reaches WATCHDOG, go to FAULT from either state.
- enable=0 mid-transaction: the current command completes (no SPI abort). The block stops in IDLE at the next step boundary and resumes at the retained index.
- The address and data outputs hold their last step's values in every state. Only the instruction output parks at 0xFF.

## Timing
- Reset values:
  - State IDLE, index 0.
  - o_CMD_Instruction 0xFF, o_CMD_Address 0x00, o_CMD_Data 0x00.
  - o_Sample_X/Y/Z 0x00.
  - o_Sample_Valid, o_Init_Done, o_Fault all 0.
  - Counters 0.
- All outputs are registered. o_CMD_* change one cycle after the state transition that selects them.
- Acceptance is detected one cycle after the handler drops ready (rdy_q delay). Command outputs must stay stable until BUSY is entered.
- Capture happens in the cycle after rdy_q rises. i_CMD_Data is already stable then, because the handler updates it before returning ready.
- o_Sample_Valid is high for exactly one clk, coincident with o_Sample_Z taking its new value.
- GAP lasts exactly SAMPLE_GAP cycles from the CAPTURE of step 5 to entry into ISSUE.
- If ISSUE is entered while rdy_q=0, the block waits in ISSUE (the watchdog runs) until rdy_q rises and then falls.
- Reset assertion in any state returns all outputs to their reset values immediately (asynchronous).

## Test plan
- Init sequence: hold enable=1, with a handler model that drops ready 4 cycles after a non-0xFF instruction and re-raises it 50 cycles later. Expect commands (0x0A,0x1F,0x52), (0x0A,0x2C,0x13), (0x0A,0x2D,0x02) in order, and o_Init_Done=1 after the third.
- Poll: the model returns 0x11/0x22/0x33 for addresses 0x08/0x09/0x0A. Expect one o_Sample_Valid pulse with X=0x11, Y=0x22, Z=0x33; the next ISSUE of address 0x08 exactly SAMPLE_GAP cycles later; the index never returns to 0.
- Enable drop: deassert enable during BUSY of step 4. The step-4 read completes, Y is updated, the block sits in IDLE with instruction 0xFF. Re-enable: the next command is READ 0x0A.
- Watchdog: the model never drops ready. Expect o_Fault=1 after WATCHDOG cycles in ISSUE, instruction 0xFF, and no further commands.
- Async reset: assert reset_n=0 mid-GAP after valid samples. Expect all outputs at reset values the same cycle; after release the init sequence restarts at step 0.

Source files
------------

// File: rtl/accel_sequencer.sv
// Accelerometer command sequencer: runs the three init writes, then polls
// the X/Y/Z data registers through the SPI command handler at a fixed interval.
module accel_sequencer #(
  parameter int SAMPLE_GAP = 1000000,
  parameter int WATCHDOG   = 2000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       i_CMD_Ready,
  input  logic [7:0] i_CMD_Data,
  output logic [7:0] o_CMD_Instruction,
  output logic [7:0] o_CMD_Address,
  output logic [7:0] o_CMD_Data,
  output logic [7:0] o_Sample_X,
  output logic [7:0] o_Sample_Y,
  output logic [7:0] o_Sample_Z,
  output logic       o_Sample_Valid,
  output logic       o_Init_Done,
  output logic       o_Fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_CAPTURE,
    S_GAP,
    S_FAULT
  } state_t;

  localparam logic [7:0] INSTR_WRITE = 8'h0A;
  localparam logic [7:0] INSTR_READ  = 8'h0B;
  localparam logic [7:0] INSTR_NONE  = 8'hFF;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        rdy_q;
  logic        armed_q, armed_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] gap_q, gap_d;
  logic [7:0]  instr_q, instr_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  z_q, z_d;
  logic        valid_q, valid_d;
  logic        init_q, init_d;
  logic        fault_q, fault_d;

  logic [7:0]  stepInstr, stepAddr, stepData;

  // Step table: three init writes followed by the three axis reads.
  always_comb begin
    stepInstr = INSTR_NONE;
    stepAddr  = 8'h00;
    stepData  = 8'h00;
    case (idx_q)
      3'd0: begin stepInstr = INSTR_WRITE; stepAddr = 8'h1F; stepData = 8'h52; end
      3'd1: begin stepInstr = INSTR_WRITE; stepAddr = 8'h2C; stepData = 8'h13; end
      3'd2: begin stepInstr = INSTR_WRITE; stepAddr = 8'h2D; stepData = 8'h02; end
      3'd3: begin stepInstr = INSTR_READ;  stepAddr = 8'h08; end
      3'd4: begin stepInstr = INSTR_READ;  stepAddr = 8'h09; end
      3'd5: begin stepInstr = INSTR_READ;  stepAddr = 8'h0A; end
      default: ;
    endcase
  end

  // Next-state, counters, captures and registered output values.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    valid_d = 1'b0;
    init_d  = init_q;

    case (state_q)
      S_IDLE: begin
        if (enable && rdy_q) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Acceptance means ready was seen high and has since dropped.
        armed_d = armed_q | rdy_q;
        wd_d    = wd_q + 32'd1;
        if (armed_q && !rdy_q) state_d = S_BUSY;
      end
      S_BUSY: begin
        wd_d = wd_q + 32'd1;
        if (rdy_q) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        case (idx_q)
          3'd3: x_d = i_CMD_Data;
          3'd4: y_d = i_CMD_Data;
          3'd5: z_d = i_CMD_Data;
          default: ;
        endcase
        if (idx_q == 3'd2) init_d = 1'b1;
        if (idx_q == 3'd5) begin
          valid_d = 1'b1;
          gap_d   = 32'd0;
          state_d = S_GAP;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = enable ? S_ISSUE : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == 32'(SAMPLE_GAP - 1)) begin
          idx_d   = 3'd3;
          state_d = enable ? S_ISSUE : S_IDLE;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      S_FAULT: ;
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_ISSUE || state_q == S_BUSY) && wd_q == 32'(WATCHDOG - 1))
      state_d = S_FAULT;

    if (state_d != state_q && (state_d == S_ISSUE || state_d == S_BUSY))
      wd_d = 32'd0;
    if (state_d == S_ISSUE && state_q != S_ISSUE)
      armed_d = 1'b0;

    fault_d = fault_q | (state_d == S_FAULT);

    instr_d = (state_q == S_ISSUE) ? stepInstr : INSTR_NONE;
    addr_d  = (state_q == S_ISSUE) ? stepAddr  : addr_q;
    data_d  = (state_q == S_ISSUE) ? stepData  : data_q;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      rdy_q   <= 1'b0;
      armed_q <= 1'b0;
      wd_q    <= 32'd0;
      gap_q   <= 32'd0;
      instr_q <= INSTR_NONE;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      z_q     <= 8'h00;
      valid_q <= 1'b0;
      init_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdy_q   <= i_CMD_Ready;
      armed_q <= armed_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      valid_q <= valid_d;
      init_q  <= init_d;
      fault_q <= fault_d;
    end
  end

  assign o_CMD_Instruction = instr_q;
  assign o_CMD_Address     = addr_q;
  assign o_CMD_Data        = data_q;
  assign o_Sample_X        = x_q;
  assign o_Sample_Y        = y_q;
  assign o_Sample_Z        = z_q;
  assign o_Sample_Valid    = valid_q;
  assign o_Init_Done       = init_q;
  assign o_Fault           = fault_q;

endmodule

// File: tb/tb_accel_sequencer.sv
// Bench for accel_sequencer: a simple SPI handler model answers commands,
// a monitor logs every command and sample pulse, and the main sequence
// compares the log against a hand-written command table.
module tb_accel_sequencer;

  localparam int GAP = 20;
  localparam int WD  = 200;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       i_CMD_Ready;
  logic [7:0] i_CMD_Data;
  logic [7:0] o_CMD_Instruction;
  logic [7:0] o_CMD_Address;
  logic [7:0] o_CMD_Data;
  logic [7:0] o_Sample_X;
  logic [7:0] o_Sample_Y;
  logic [7:0] o_Sample_Z;
  logic       o_Sample_Valid;
  logic       o_Init_Done;
  logic       o_Fault;

  accel_sequencer #(.SAMPLE_GAP(GAP), .WATCHDOG(WD)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .i_CMD_Ready       (i_CMD_Ready),
    .i_CMD_Data        (i_CMD_Data),
    .o_CMD_Instruction (o_CMD_Instruction),
    .o_CMD_Address     (o_CMD_Address),
    .o_CMD_Data        (o_CMD_Data),
    .o_Sample_X        (o_Sample_X),
    .o_Sample_Y        (o_Sample_Y),
    .o_Sample_Z        (o_Sample_Z),
    .o_Sample_Valid    (o_Sample_Valid),
    .o_Init_Done       (o_Init_Done),
    .o_Fault           (o_Fault)
  );

  typedef struct {
    logic [7:0] instr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] reply;
    logic       initDone;
  } vec_t;

  vec_t vec[9];

  int passCount  = 0;
  int totalCount = 0;
  int cyc        = 0;

  int         cmdCount = 0;
  logic [7:0] cmdInstr[64];
  logic [7:0] cmdAddr[64];
  logic [7:0] cmdData[64];
  logic       cmdInit[64];
  int         cmdCyc[64];

  int         validCount = 0;
  int         validLong  = 0;
  logic [7:0] vx[8];
  logic [7:0] vy[8];
  logic [7:0] vz[8];
  int         validCyc[8];

  logic stuck     = 1'b0;
  int   acceptIdx = 0;

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Handler model: drops ready 4 cycles after seeing a command, raises it
  // again 50 cycles later with the table's reply byte.
  initial begin
    int cnt;
    logic busy;
    cnt = 0;
    busy = 1'b0;
    i_CMD_Ready = 1'b1;
    i_CMD_Data = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        i_CMD_Ready = 1'b1;
        cnt = 0;
        busy = 1'b0;
      end else if (!busy) begin
        if (!stuck && i_CMD_Ready && o_CMD_Instruction != 8'hFF) begin
          cnt = cnt + 1;
          if (cnt == 4) begin
            i_CMD_Ready = 1'b0;
            busy = 1'b1;
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        cnt = cnt + 1;
        if (cnt == 50) begin
          i_CMD_Data = (acceptIdx < 9) ? vec[acceptIdx].reply : 8'h00;
          acceptIdx = acceptIdx + 1;
          i_CMD_Ready = 1'b1;
          busy = 1'b0;
          cnt = 0;
        end
      end
    end
  end

  // Monitor: logs each new command and each sample-valid pulse.
  initial begin
    logic [7:0] prevInstr;
    logic prevValid;
    prevInstr = 8'hFF;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prevInstr = 8'hFF;
        prevValid = 1'b0;
      end else begin
        if (o_CMD_Instruction != 8'hFF && prevInstr == 8'hFF && cmdCount < 64) begin
          cmdInstr[cmdCount] = o_CMD_Instruction;
          cmdAddr[cmdCount]  = o_CMD_Address;
          cmdData[cmdCount]  = o_CMD_Data;
          cmdInit[cmdCount]  = o_Init_Done;
          cmdCyc[cmdCount]   = cyc;
          cmdCount = cmdCount + 1;
        end
        prevInstr = o_CMD_Instruction;
        if (o_Sample_Valid) begin
          if (prevValid) validLong = validLong + 1;
          if (validCount < 8) begin
            vx[validCount] = o_Sample_X;
            vy[validCount] = o_Sample_Y;
            vz[validCount] = o_Sample_Z;
            validCyc[validCount] = cyc;
          end
          validCount = validCount + 1;
        end
        prevValid = o_Sample_Valid;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCount = totalCount + 1;
    if (actual === expected) passCount = passCount + 1;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic en);
    @(negedge clk);
    enable = en;
  endtask

  task automatic waitCmds(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (cmdCount < n && i < budget) begin
      @(posedge clk);
      i = i + 1;
    end
    checkOutput(name, 32'(cmdCount >= n), 32'd1);
  endtask

  task automatic waitValid(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (validCount < n && i < budget) begin
      @(posedge clk);
      i = i + 1;
    end
    checkOutput(name, 32'(validCount >= n), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_instr"}, 32'(o_CMD_Instruction), 32'h FF);
    checkOutput({tag, "_addr"},  32'(o_CMD_Address), 32'h0);
    checkOutput({tag, "_data"},  32'(o_CMD_Data), 32'h0);
    checkOutput({tag, "_x"},     32'(o_Sample_X), 32'h0);
    checkOutput({tag, "_y"},     32'(o_Sample_Y), 32'h0);
    checkOutput({tag, "_z"},     32'(o_Sample_Z), 32'h0);
    checkOutput({tag, "_valid"}, 32'(o_Sample_Valid), 32'h0);
    checkOutput({tag, "_init"},  32'(o_Init_Done), 32'h0);
    checkOutput({tag, "_fault"}, 32'(o_Fault), 32'h0);
  endtask

  // Main test sequence.
  initial begin
    int n;
    int obs;
    int i;

    vec[0] = '{8'h0A, 8'h1F, 8'h52, 8'h00, 1'b0};
    vec[1] = '{8'h0A, 8'h2C, 8'h13, 8'h00, 1'b0};
    vec[2] = '{8'h0A, 8'h2D, 8'h02, 8'h00, 1'b0};
    vec[3] = '{8'h0B, 8'h08, 8'h00, 8'h11, 1'b1};
    vec[4] = '{8'h0B, 8'h09, 8'h00, 8'h22, 1'b1};
    vec[5] = '{8'h0B, 8'h0A, 8'h00, 8'h33, 1'b1};
    vec[6] = '{8'h0B, 8'h08, 8'h00, 8'h55, 1'b1};
    vec[7] = '{8'h0B, 8'h09, 8'h00, 8'h44, 1'b1};
    vec[8] = '{8'h0B, 8'h0A, 8'h00, 8'h66, 1'b1};

    $display("[TB] start");
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset_n = 1'b1;

    // Init sequence and first poll round.
    applyStimulus(1'b1);
    waitCmds(7, 3000, "wait_cmd6");
    checkOutput("valid_count_1", 32'(validCount), 32'd1);
    checkOutput("gap_len", 32'(cmdCyc[6] - validCyc[0]), 32'(GAP + 1));
    checkOutput("valid1_x", 32'(vx[0]), 32'h11);
    checkOutput("valid1_y", 32'(vy[0]), 32'h22);
    checkOutput("valid1_z", 32'(vz[0]), 32'h33);

    // Drop enable while the step-4 read is in BUSY.
    waitCmds(8, 1000, "wait_cmd7");
    i = 0;
    @(negedge clk);
    while (o_CMD_Instruction != 8'hFF && i < 30) begin
      @(negedge clk);
      i = i + 1;
    end
    checkOutput("busy_reached", 32'(o_CMD_Instruction), 32'hFF);
    enable = 1'b0;
    repeat (150) @(negedge clk);
    checkOutput("drop_y", 32'(o_Sample_Y), 32'h44);
    checkOutput("drop_x", 32'(o_Sample_X), 32'h55);
    checkOutput("drop_instr", 32'(o_CMD_Instruction), 32'hFF);
    @(posedge clk);
    checkOutput("drop_no_cmd", 32'(cmdCount), 32'd8);
    checkOutput("drop_no_valid", 32'(validCount), 32'd1);

    applyStimulus(1'b1);
    waitCmds(9, 1000, "wait_cmd8");

    // Command log against the table.
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("cmd%0d_instr", k), 32'(cmdInstr[k]), 32'(vec[k].instr));
      checkOutput($sformatf("cmd%0d_addr", k),  32'(cmdAddr[k]),  32'(vec[k].addr));
      checkOutput($sformatf("cmd%0d_data", k),  32'(cmdData[k]),  32'(vec[k].data));
      checkOutput($sformatf("cmd%0d_init", k),  32'(cmdInit[k]),  32'(vec[k].initDone));
    end

    waitValid(2, 1000, "wait_valid2");
    checkOutput("valid2_x", 32'(vx[1]), 32'h55);
    checkOutput("valid2_y", 32'(vy[1]), 32'h44);
    checkOutput("valid2_z", 32'(vz[1]), 32'h66);
    checkOutput("valid_one_cycle", 32'(validLong), 32'd0);

    // Asynchronous reset in the middle of GAP.
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 checkResetValues("async");
    @(negedge clk);
    reset_n = 1'b1;
    n = cmdCount;
    waitCmds(n + 1, 500, "wait_restart");
    checkOutput("restart_instr", 32'(cmdInstr[n]), 32'h0A);
    checkOutput("restart_addr",  32'(cmdAddr[n]),  32'h1F);
    checkOutput("restart_data",  32'(cmdData[n]),  32'h52);
    checkOutput("restart_init",  32'(cmdInit[n]),  32'h0);

    // Watchdog: handler never accepts.
    @(negedge clk);
    reset_n = 1'b0;
    stuck = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n = cmdCount;
    waitCmds(n + 1, 100, "wait_wd_cmd");
    obs = cmdCyc[n];
    @(negedge clk);
    while (cyc < obs + WD - 3) @(negedge clk);
    checkOutput("wd_not_yet", 32'(o_Fault), 32'h0);
    while (cyc < obs + WD + 3) @(negedge clk);
    checkOutput("wd_fault", 32'(o_Fault), 32'h1);
    checkOutput("wd_instr", 32'(o_CMD_Instruction), 32'hFF);
    repeat (50) @(negedge clk);
    checkOutput("wd_fault_sticky", 32'(o_Fault), 32'h1);
    @(posedge clk);
    checkOutput("wd_no_more_cmds", 32'(cmdCount), 32'(n + 1));

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: got time limit, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
